// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Registered ShiftRows / InvShiftRows stage for a Rijndael datapath with
//   NB = 4, 6 or 8 state columns. The byte permutation is applied on the way
//   in. Shifted states are then held in a 2-entry FIFO behind a valid/ready
//   handshake. Every output is a flop, so in_ready does not depend on
//   out_ready through any combinational path.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; discards all buffered entries
//   in_valid   in_state / in_mode present
//   in_ready   stage can accept (registered, low only when both entries full)
//   in_state   input state, byte k = bits [8k:8k+7], row k%4, column k/4
//   in_mode    0 = forward ShiftRows, 1 = inverse
//   out_valid  out_state / out_mode valid
//   out_ready  downstream accepts
//   out_state  shifted state at the FIFO head, same byte layout
//   out_mode   mode travelling with the head entry
//   occupancy  number of entries held (0..2)

module shift_rows_pipe #(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:W-1] in_state,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_state,
    output logic         out_mode,
    output logic [1:0]   occupancy
);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8 (got %0d)", NB);
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e         occ_q, occ_d;
    logic [0:W-1] head_state_q, head_state_d;
    logic [0:W-1] tail_state_q, tail_state_d;
    logic         head_mode_q, head_mode_d;
    logic         tail_mode_q, tail_mode_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [0:W-1] fwd_state;
    logic [0:W-1] inv_state;
    logic [0:W-1] shifted;
    logic         push;
    logic         pop;

    // Both permutations are pure wiring; the row offset for NB=8 skips 2,
    // giving {0,1,3,4} instead of {0,1,2,3}.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FWD = (c + SH) % NB;
            localparam int INV = (c + NB - SH) % NB;
            assign fwd_state[8*(r+4*c) +: 8] = in_state[8*(r+4*FWD) +: 8];
            assign inv_state[8*(r+4*c) +: 8] = in_state[8*(r+4*INV) +: 8];
        end
    end

    always_comb begin
        shifted = in_mode ? inv_state : fwd_state;
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        occ_d        = occ_q;
        head_state_d = head_state_q;
        head_mode_d  = head_mode_q;
        tail_state_d = tail_state_q;
        tail_mode_d  = tail_mode_q;

        case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_state_d = shifted;
                    head_mode_d  = in_mode;
                    occ_d        = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new entry takes its place directly.
                    head_state_d = shifted;
                    head_mode_d  = in_mode;
                end else if (push) begin
                    tail_state_d = shifted;
                    tail_mode_d  = in_mode;
                    occ_d        = FULL;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_state_d = tail_state_q;
                    head_mode_d  = tail_mode_q;
                    occ_d        = ONE;
                end
            end
            default: begin
                occ_d = EMPTY;
            end
        endcase

        // Flag flops track the next occupancy so they stay a pure decode.
        in_ready_d  = (occ_d != FULL);
        out_valid_d = (occ_d != EMPTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q        <= EMPTY;
            head_state_q <= '0;
            head_mode_q  <= 1'b0;
            tail_state_q <= '0;
            tail_mode_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            head_state_q <= head_state_d;
            head_mode_q  <= head_mode_d;
            tail_state_q <= tail_state_d;
            tail_mode_q  <= tail_mode_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = head_state_q;
    assign out_mode  = head_mode_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Testbench for shift_rows_pipe: NB=4 instance with a scoreboard, plus
// NB=6 and NB=8 instances for round-trip checks.

module tb_shift_rows_pipe;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // NB = 4
    logic         in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_mode4;
    logic [0:127] in_state4, out_state4;
    logic [1:0]   occ4;
    // NB = 6
    logic         in_valid6, in_ready6, in_mode6, out_valid6, out_ready6, out_mode6;
    logic [0:191] in_state6, out_state6;
    logic [1:0]   occ6;
    // NB = 8
    logic         in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_mode8;
    logic [0:255] in_state8, out_state8;
    logic [1:0]   occ8;

    shift_rows_pipe #(.NB(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4), .out_mode(out_mode4),
        .occupancy(occ4)
    );

    shift_rows_pipe #(.NB(6)) u_dut6 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_state(in_state6), .in_mode(in_mode6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_state(out_state6), .out_mode(out_mode6),
        .occupancy(occ6)
    );

    shift_rows_pipe #(.NB(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_state(in_state8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_state(out_state8), .out_mode(out_mode8),
        .occupancy(occ8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference ShiftRows on a left-aligned state of nb columns.
    function automatic logic [0:255] ref_shift(input logic [0:255] s, input int nb, input logic inv);
        logic [0:255] o;
        int offs8 [4] = '{0, 1, 3, 4};
        int sh;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8) ? offs8[r] : r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
                o[8*(r+4*c) +: 8] = s[8*(r+4*src) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:255] seq_bytes(input int nb);
        logic [0:255] s;
        logic [7:0]   b;
        s = '0;
        for (int k = 0; k < 4 * nb; k++) begin
            b = 8'(k);
            s[8*k +: 8] = b;
        end
        return s;
    endfunction

    function automatic logic [0:127] ref4(input logic [0:127] s, input logic inv);
        logic [0:255] t;
        t = ref_shift({s, 128'h0}, 4, inv);
        return t[0:127];
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard for the NB=4 instance.
    logic [0:127] exp_st [$];
    logic         exp_md [$];
    int           pops = 0;

    always @(negedge clk) begin : monitor
        logic [0:127] es;
        logic         em;
        if (reset) begin
            exp_st.delete();
            exp_md.delete();
        end else begin
            if (out_valid4 && out_ready4) begin
                if (exp_st.size() == 0) begin
                    chk("unexpected output", {255'h0, out_valid4}, 256'h0);
                end else begin
                    es = exp_st.pop_front();
                    em = exp_md.pop_front();
                    chk("sb state", out_state4, es);
                    chk("sb mode", out_mode4, em);
                    pops++;
                end
            end
            if (in_valid4 && in_ready4) begin
                exp_st.push_back(ref4(in_state4, in_mode4));
                exp_md.push_back(in_mode4);
            end
        end
    end

    task automatic send4(input logic [0:127] st, input logic m);
        in_state4 = st;
        in_mode4  = m;
        in_valid4 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready4) break;
        end
        chk("accept timeout", in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic drain4();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (exp_st.size() == 0) break;
        end
        chk("drain", exp_st.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:255] sq;
        logic [0:127] sq4, fwd4, inv4, a, b, c, ra, rb, rc;
        logic [0:255] sq8, f8, t8;
        logic [0:191] sq6, f6;
        logic [0:255] t6;
        logic [31:0]  col0;
        int unsigned  c0;
        int           p0;

        in_valid4 = 0; in_mode4 = 0; in_state4 = '0; out_ready4 = 0;
        in_valid6 = 0; in_mode6 = 0; in_state6 = '0; out_ready6 = 1;
        in_valid8 = 0; in_mode8 = 0; in_state8 = '0; out_ready8 = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready4, 1);
        chk("rst out_valid", out_valid4, 0);
        chk("rst occupancy", occ4, 0);
        chk("rst out_state", out_state4, 0);
        chk("rst out_mode", out_mode4, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // NB=4 forward / inverse with known vectors
        sq   = seq_bytes(4);
        sq4  = sq[0:127];
        fwd4 = 128'h00050a0f_04090e03_080d0207_0c01060b;
        inv4 = 128'h000d0a07_04010e0b_0805020f_0c090603;
        out_ready4 = 1'b1;
        in_state4 = sq4; in_mode4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1; in_valid4 = 1'b0;
        chk("nb4 fwd valid", out_valid4, 1);
        chk("nb4 fwd state", out_state4, fwd4);
        chk("nb4 fwd mode", out_mode4, 0);
        @(posedge clk); #1;
        in_state4 = sq4; in_mode4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1; in_valid4 = 1'b0;
        chk("nb4 inv state", out_state4, inv4);
        chk("nb4 inv mode", out_mode4, 1);
        @(posedge clk); #1;
        in_state4 = inv4; in_mode4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1; in_valid4 = 1'b0;
        chk("nb4 round trip", out_state4, sq4);
        drain4();
        @(posedge clk); #1;

        // Backpressure: A, B accepted, C held until space frees
        a = rnd128(); b = rnd128(); c = rnd128();
        ra = ref4(a, 0); rb = ref4(b, 1); rc = ref4(c, 0);
        out_ready4 = 1'b0;
        in_state4 = a; in_mode4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_state4 = b; in_mode4 = 1'b1;
        @(posedge clk); #1;
        in_state4 = c; in_mode4 = 1'b0;
        chk("bp in_ready low", in_ready4, 0);
        chk("bp occ full", occ4, 2);
        chk("bp head A", out_state4, ra);
        chk("bp head mode", out_mode4, 0);
        @(posedge clk); #1;
        chk("bp still full", occ4, 2);
        chk("bp head stable", out_state4, ra);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("bp ready back", in_ready4, 1);
        chk("bp head B", out_state4, rb);
        chk("bp head B mode", out_mode4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        chk("bp occ one", occ4, 1);
        chk("bp head C", out_state4, rc);
        drain4();
        @(posedge clk); #1;
        chk("bp empty ready", in_ready4, 1);
        chk("bp empty occ", occ4, 0);

        // Streaming with alternating modes
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            send4(rnd128(), 1'(i % 2));
            chk("stream occ", occ4, 1);
            chk("stream valid", out_valid4, 1);
        end
        chk("stream cycles", cyc - c0, 16);
        drain4();
        chk("stream pops", pops - p0, 16);
        @(posedge clk); #1;

        // Reset while full
        out_ready4 = 1'b0;
        send4(rnd128(), 1'b0);
        send4(rnd128(), 1'b1);
        chk("rstmid occ full", occ4, 2);
        #2 reset = 1'b1;
        #1;
        chk("rstmid out_valid", out_valid4, 0);
        chk("rstmid occ", occ4, 0);
        chk("rstmid in_ready", in_ready4, 1);
        chk("rstmid out_state", out_state4, 0);
        chk("rstmid out_mode", out_mode4, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstmid no stale", out_valid4, 0);
        end

        // NB=8 forward, column 0 and round trip
        sq8 = seq_bytes(8);
        in_state8 = sq8; in_mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1; in_valid8 = 1'b0;
        chk("nb8 valid", out_valid8, 1);
        f8 = out_state8;
        col0 = f8[0:31];
        chk("nb8 col0", col0, 32'h00050e13);
        chk("nb8 fwd", f8, ref_shift(sq8, 8, 0));
        in_state8 = f8; in_mode8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1; in_valid8 = 1'b0;
        t8 = out_state8;
        chk("nb8 round trip", t8, sq8);
        chk("nb8 inv mode", out_mode8, 1);

        // NB=6 round trip
        t6  = seq_bytes(6);
        sq6 = t6[0:191];
        in_state6 = sq6; in_mode6 = 1'b0; in_valid6 = 1'b1;
        @(posedge clk); #1; in_valid6 = 1'b0;
        chk("nb6 valid", out_valid6, 1);
        f6 = out_state6;
        t6 = ref_shift({sq6, 64'h0}, 6, 0);
        chk("nb6 fwd", f6, t6[0:191]);
        in_state6 = f6; in_mode6 = 1'b1; in_valid6 = 1'b1;
        @(posedge clk); #1; in_valid6 = 1'b0;
        chk("nb6 round trip", out_state6, sq6);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Registered, parametrised ShiftRows/InvShiftRows stage for the Rijndael datapath. It supports block widths of 128, 192 and 256 bits (NB = 4, 6, 8 columns). The cipher direction is selectable per transaction. A valid/ready handshake and a 2-entry output buffer let it drop between round stages of a pipelined encryptor/decryptor without combinational ready paths.

## Interface
- NB, 4: number of state columns. Legal values are 4, 6, 8; any other value is an elaboration error.
- W, 32*NB (derived, not overridable): state width in bits.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_state/in_mode present
- in_ready  output  1  block can accept (registered)
- in_state  input  [0:W-1]  input state; byte k = bits [8k:8k+7], row r = k mod 4, column c = k div 4
- in_mode  input  1  0 = forward ShiftRows, 1 = inverse
- out_valid  output  1  out_state/out_mode valid
- out_ready  input  1  downstream accepts
- out_state  output  [0:W-1]  shifted state, same byte layout
- out_mode  output  1  mode of the transaction at the head
- occupancy  output  2  entries held (0..2)

## Operation
- Row offsets s_r:
  - NB=4 and NB=6: s = {0,1,2,3}.
  - NB=8: s = {0,1,3,4}.
- Forward mode: out[r][c] = in[r][(c + s_r) mod NB].
- Inverse mode: out[r][c] = in[r][(c − s_r + NB) mod NB].
- The permutation is computed combinationally on the input side and stored already shifted. out_state is a register output.
- Storage is a 2-entry FIFO (head, tail) of {state, mode}.
  - Input handshake: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
- occupancy states are EMPTY(0), ONE(1), FULL(2):
  - EMPTY: accept → ONE.
  - ONE:
    - accept only → FULL.
    - pop only → EMPTY.
    - accept and pop together → ONE; the new entry becomes head.
  - FULL: pop → ONE; tail moves to head. No accept is possible in FULL.
- in_ready = (occupancy != 2). It is a registered decode; there is no combinational path from out_ready.
- out_valid = (occupancy != 0).
- Data is never dropped, duplicated or reordered. in_mode travels with its state.
- The head may not change while out_valid && !out_ready: out_state and out_mode are held stable.

## Timing
- Reset values: in_ready=1, out_valid=0, occupancy=0, out_state=0, out_mode=0.
- Reset is asynchronous and takes effect immediately mid-transaction. All buffered entries are discarded.
- First accept after reset release is allowed on the first rising edge where in_valid=1.
- Latency: a transaction accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 transaction/cycle sustained when out_ready is held 1.
- Backpressure:
  - After 2 accepts without a pop, in_ready drops in the following cycle.
  - A pop from FULL raises in_ready in the next cycle.
- Simultaneous push/pop in ONE: occupancy stays 1. out_state updates to the new entry at that edge.
- in_state, in_mode and in_valid are ignored when in_ready=0.

## Test plan
- **NB=4 forward.** in_state = bytes 00..0f (byte k = k), mode 0, out_ready=1 → one cycle later out_valid=1, out_state = 128'h00050a0f_04090e03_080d0207_0c01060b, out_mode=0.
- **NB=4 inverse.** Same input, mode 1 → out_state = 128'h000d0a07_04010e0b_0805020f_0c090603. Feeding this back with mode 0 returns 00..0f.
- **NB=8 forward.** Bytes 00..1f, mode 0 → column 0 = 00 05 0e 13. Inverse of that output returns 00..1f. Repeat the round-trip for NB=6.
- **Backpressure.** out_ready=0, present 3 back-to-back transactions A, B, C:
  - A and B are accepted; in_ready=0 with occupancy=2; C is held.
  - out_state stays A while stalled.
  - Raise out_ready → A, B, C emerge in order with correct modes; in_ready returns 1.
- **Streaming.** 16 random transactions with alternating modes, out_ready=1 → one output per cycle, occupancy stays 1, results match a reference model.
- **Reset mid-stream.** Assert reset while occupancy=2 → out_valid=0, occupancy=0, in_ready=1, out_state=0 immediately (before the next edge). No stale data appears after release.
